clk_divider_bank: RTL and testbench
===================================

# clk_divider_bank

Multi-channel, runtime-programmable clock/strobe divider for the VGA game fabric. Each of `CH` channels divides `I_CLK` by a programmable period with programmable high time. Each channel drives a registered divided level and a one-cycle tick strobe on every rising edge of that level. Configuration is double-buffered and applied only at a period boundary, so pixel, animation and game-tick timebases are retuned without runt pulses.

## Interface
- `CH`, 4, number of independent channels
- `W`, 16, width of period/high/phase fields
- `DEF_DIV`, 20, period loaded into every channel at reset
- `DEF_HIGH`, `DEF_DIV/2`, high time loaded into every channel at reset

Ports. One clock; reset is asynchronous and active-low.
- `I_CLK`  in  1  system clock; all state updates on its rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `en`  in  CH  per-channel run enable
- `sync`  in  1  one-cycle pulse; restarts all enabled channels together
- `cfg_valid`  in  1  config write request
- `cfg_ready`  out  1  `!pending[cfg_ch]` (combinational)
- `cfg_ch`  in  clog2(CH)  target channel
- `cfg_div`  in  W  new period in cycles
- `cfg_high`  in  W  new high time in cycles
- `cfg_phase`  in  W  new start offset (present only with `CLKDIV_PHASE_EN`)
- `O_CLK`  out  CH  divided clock level per channel, registered
- `tick`  out  CH  one-cycle strobe when `O_CLK[i]` rises, registered

## Operation
- Per-channel state:
  - active `div`, `high`, `phase`
  - shadow `div`, `high`, `phase`
  - `pending` flag
  - counter `cnt`, W bits
- Effective values:
  - `div_e = max(div, 2)`
  - `thr = div_e - min(high, div_e)`
  - `phase_e = (phase < div_e) ? phase : 0`
- Enabled channel, each edge:
  - `cnt_n = (cnt == div_e-1) ? 0 : cnt+1`
  - `O_CLK <= (cnt_n >= thr)`
  - `tick <= (cnt_n >= thr) & ~O_CLK`
- Resulting waveform:
  - period is exactly `div_e` cycles, high for `min(high, div_e)` cycles, low first
  - `high = 0`: `O_CLK` stays 0 and `tick` never fires
  - `high >= div_e`: `O_CLK` stays 1, with one `tick` after start only
- Disabled channel:
  - `cnt` held at 0, `O_CLK = 0`, `tick = 0`
  - `en` rising: next edge loads `cnt = phase_e` and `O_CLK = (phase_e >= thr)`; no tick on that edge
- `sync`:
  - every enabled channel loads `cnt = phase_e` and `O_CLK = (phase_e >= thr)`
  - any pending shadow config is applied first
  - `tick` is suppressed on that edge
  - `sync` has priority over wrap
- Config write (`cfg_valid & cfg_ready`):
  - writes the shadow registers of `cfg_ch` and sets its `pending`
- Pending config becomes active when any of these occurs:
  - the same edge where `cnt_n == 0` (wrap)
  - the next edge while the channel is disabled
  - on `sync`
- On activation `pending` clears, and `cfg_ready` rises the following cycle.
- Simultaneous write and activation on the same channel cannot occur, because `cfg_ready` is low while pending.
- Reset: all `cnt = 0`, `O_CLK = 0`, `tick = 0`, `pending = 0`, active = shadow = (`DEF_DIV`, `DEF_HIGH`, 0).

## Timing
- Latency from `en` sampled high to first counter advance: 1 cycle. The load edge counts as cycle 0.
- Default channel enabled from reset (`DEF_DIV` 20, high 10):
  - `O_CLK` rises on the 10th edge, when `cnt` = 10, with `tick` high that cycle
  - `O_CLK` falls on the 20th edge, when `cnt` = 0
- `rst_n` asserted mid-period: outputs go to 0 asynchronously. The first period after release is full-length.
- Counter never exceeds `div_e-1`; a shadow `div` smaller than the current `cnt` cannot occur, because activation happens only at wrap or restart.

## Configuration
- `CLKDIV_PHASE_EN` defined:
  - `cfg_phase` port and per-channel phase registers exist
  - restarts load `phase_e`
- Not defined:
  - port absent and `phase_e = 0` constant
  - all restarts begin at `cnt = 0`

## Structure
- Shared package `clkdiv_pkg`:
  - `CLKDIV_W` default width constant
  - `clkdiv_cfg_t` struct: `div`, `high`, `phase`
  - reset-default constants
- One sub-module, `clkdiv_chan`: a single channel (counter, shadow/active registers, pending, output logic).
- Top level instantiates `CH` copies in a generate loop, decodes `cfg_ch`, and muxes `cfg_ready`.

## Test plan
- Reset, `en=1` on channel 0 with defaults -> `O_CLK[0]` period 20, high 10; `tick[0]` exactly once per 20 cycles, coincident with the rising edge.
- Write ch1 `div`=5, `high`=2 mid-period while running `div` 8 -> `cfg_ready` low until the wrap; old period completes at 8; next periods are 5 with 2 cycles high.
- `div`=0, `high`=1 -> treated as `div_e` 2: alternating 1/0 each cycle; `high`=0 -> constant 0, no ticks; `high`=9 with `div`=4 -> constant 1 after start, one tick.
- Ch0 `div` 6, ch2 `div` 12 running out of phase, `sync` pulse -> both restart at `cnt` 0 and rise together 3 and 6 cycles later; no tick on the `sync` edge.
- `CLKDIV_PHASE_EN`, `div` 10, `high` 5, `phase` 7, `en` rises -> `O_CLK` high on the load edge, falls 3 edges later; `phase` 12 -> behaves as `phase` 0.
- Assert `rst_n` low mid-high-phase -> `O_CLK`/`tick` drop asynchronously; a pending config is discarded and defaults are restored.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the programmable clock divider bank.
// Effective-value helpers clamp raw config into a legal waveform.
package clkdiv_pkg;

    localparam int CLKDIV_W       = 16;
    localparam int CLKDIV_DEF_DIV = 20;

    typedef logic [CLKDIV_W-1:0] cval_t;

    typedef struct packed {
        cval_t div;
        cval_t high;
        cval_t phase;
    } clkdiv_cfg_t;

    function automatic cval_t div_eff(input cval_t d);
        return (d < cval_t'(2)) ? cval_t'(2) : d;
    endfunction

    // Counter value at which the level goes high; low part comes first.
    function automatic cval_t thr_eff(input clkdiv_cfg_t c);
        cval_t de;
        de = div_eff(c.div);
        return de - ((c.high < de) ? c.high : de);
    endfunction

    function automatic cval_t phase_eff(input clkdiv_cfg_t c);
        return (c.phase < div_eff(c.div)) ? c.phase : '0;
    endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: counter, double-buffered config, level and tick.
// New config takes effect only at wrap, restart, or while disabled.
module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int DEF_DIV  = CLKDIV_DEF_DIV,
    parameter int DEF_HIGH = CLKDIV_DEF_DIV / 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                sync,
    input  logic                wr,
    input  logic [CLKDIV_W-1:0] cfg_div,
    input  logic [CLKDIV_W-1:0] cfg_high,
    input  logic [CLKDIV_W-1:0] cfg_phase,
    output logic                pending,
    output logic                o_clk,
    output logic                tick
);

    localparam clkdiv_cfg_t DEF_CFG = '{
        div:   cval_t'(DEF_DIV),
        high:  cval_t'(DEF_HIGH),
        phase: '0
    };

    clkdiv_cfg_t act;
    clkdiv_cfg_t shd;
    clkdiv_cfg_t nxt;
    cval_t       cnt;
    cval_t       cnt_inc;
    cval_t       cnt_d;
    cval_t       thr_n;
    logic        en_q;
    logic        restart;
    logic        apply;
    logic        o_d;

    always_comb begin
        cnt_inc = (cnt == div_eff(act.div) - cval_t'(1)) ? '0
                                                         : cnt + cval_t'(1);
        restart = en & (~en_q | sync);
        apply   = pending & (~en | restart | (cnt_inc == '0));
        nxt     = apply ? shd : act;
        thr_n   = thr_eff(nxt);
        cnt_d   = '0;
        if (en) begin
            cnt_d = restart ? phase_eff(nxt) : cnt_inc;
        end
        o_d = en & (cnt_d >= thr_n);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act     <= DEF_CFG;
            shd     <= DEF_CFG;
            pending <= 1'b0;
            en_q    <= 1'b0;
            cnt     <= '0;
            o_clk   <= 1'b0;
            tick    <= 1'b0;
        end else begin
            act   <= nxt;
            en_q  <= en;
            cnt   <= cnt_d;
            o_clk <= o_d;
            // Restart edges never strobe, even if the level comes up high.
            tick  <= o_d & ~o_clk & ~restart;
            if (wr) begin
                shd     <= '{div: cfg_div, high: cfg_high, phase: cfg_phase};
                pending <= 1'b1;
            end else if (apply) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clk_divider_bank.sv
// Bank of CH runtime-programmable clock/strobe dividers.
// Optional start-phase support is enabled with CLKDIV_PHASE_EN.
module clk_divider_bank
    import clkdiv_pkg::*;
#(
    parameter int CH       = 4,
    parameter int W        = CLKDIV_W,
    parameter int DEF_DIV  = CLKDIV_DEF_DIV,
    parameter int DEF_HIGH = DEF_DIV / 2,
    localparam int CW      = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic          I_CLK,
    input  logic          rst_n,
    input  logic [CH-1:0] en,
    input  logic          sync,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [CW-1:0] cfg_ch,
    input  logic [W-1:0]  cfg_div,
    input  logic [W-1:0]  cfg_high,
`ifdef CLKDIV_PHASE_EN
    input  logic [W-1:0]  cfg_phase,
`endif
    output logic [CH-1:0] O_CLK,
    output logic [CH-1:0] tick
);

    logic [CH-1:0] pending;
    logic [CH-1:0] wr;
    cval_t         div_in;
    cval_t         high_in;
    cval_t         phase_in;

    assign div_in  = cval_t'(cfg_div);
    assign high_in = cval_t'(cfg_high);
`ifdef CLKDIV_PHASE_EN
    assign phase_in = cval_t'(cfg_phase);
`else
    // Without phase support every restart begins at count zero.
    assign phase_in = '0;
`endif

    assign cfg_ready = ~pending[cfg_ch];

    for (genvar i = 0; i < CH; i++) begin : g_chan
        assign wr[i] = cfg_valid & cfg_ready & (cfg_ch == CW'(i));

        clkdiv_chan #(
            .DEF_DIV  (DEF_DIV),
            .DEF_HIGH (DEF_HIGH)
        ) u_chan (
            .clk       (I_CLK),
            .rst_n     (rst_n),
            .en        (en[i]),
            .sync      (sync),
            .wr        (wr[i]),
            .cfg_div   (div_in),
            .cfg_high  (high_in),
            .cfg_phase (phase_in),
            .pending   (pending[i]),
            .o_clk     (O_CLK[i]),
            .tick      (tick[i])
        );
    end

endmodule

// File: tb/tb_clk_divider_bank.sv
// Self-checking bench for clk_divider_bank against a behavioural model.
// Phase scenarios run only when CLKDIV_PHASE_EN is defined.
module tb_clk_divider_bank;

    localparam int CH = 4;
    localparam int W  = 16;

    logic          I_CLK     = 1'b0;
    logic          rst_n     = 1'b0;
    logic [CH-1:0] en        = '0;
    logic          sync      = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [1:0]    cfg_ch    = '0;
    logic [W-1:0]  cfg_div   = '0;
    logic [W-1:0]  cfg_high  = '0;
`ifdef CLKDIV_PHASE_EN
    logic [W-1:0]  cfg_phase = '0;
`endif
    logic [CH-1:0] O_CLK;
    logic [CH-1:0] tick;

    clk_divider_bank dut (
        .I_CLK     (I_CLK),
        .rst_n     (rst_n),
        .en        (en),
        .sync      (sync),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_high  (cfg_high),
`ifdef CLKDIV_PHASE_EN
        .cfg_phase (cfg_phase),
`endif
        .O_CLK     (O_CLK),
        .tick      (tick)
    );

    always #5 I_CLK = ~I_CLK;

    // Model: position within the current period plus active/shadow config.
    int            md [CH];
    int            mh [CH];
    int            mp [CH];
    int            sd [CH];
    int            sh [CH];
    int            sp [CH];
    bit            mpend [CH];
    bit            mrun [CH];
    int            mpos [CH];
    logic [CH-1:0] mo;
    logic [CH-1:0] mt;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic int deff(int d);
        return (d < 2) ? 2 : d;
    endfunction

    function automatic bit lvl(int i, int p);
        int de;
        int hi;
        de = deff(md[i]);
        hi = (mh[i] < de) ? mh[i] : de;
        return p >= de - hi;
    endfunction

    function automatic int peff(int i);
        return (mp[i] < deff(md[i])) ? mp[i] : 0;
    endfunction

    task automatic activate(int i);
        md[i]    = sd[i];
        mh[i]    = sh[i];
        mp[i]    = sp[i];
        mpend[i] = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            md[i] = 20; mh[i] = 10; mp[i] = 0;
            sd[i] = 20; sh[i] = 10; sp[i] = 0;
            mpend[i] = 0;
            mrun[i]  = 0;
            mpos[i]  = 0;
        end
        mo = '0;
        mt = '0;
    endtask

    task automatic model_edge();
        bit rdy;
        bit rs;
        bit l;
        int nx;
        rdy = !mpend[cfg_ch];
        for (int i = 0; i < CH; i++) begin
            rs = en[i] && (!mrun[i] || sync);
            if (!en[i]) begin
                if (mpend[i]) activate(i);
                mpos[i] = 0;
                mo[i]   = 1'b0;
                mt[i]   = 1'b0;
            end else if (rs) begin
                if (mpend[i]) activate(i);
                mpos[i] = peff(i);
                mo[i]   = lvl(i, mpos[i]);
                mt[i]   = 1'b0;
            end else begin
                nx = (mpos[i] + 1) % deff(md[i]);
                if (nx == 0 && mpend[i]) activate(i);
                l       = lvl(i, nx);
                mt[i]   = l && !mo[i];
                mo[i]   = l;
                mpos[i] = nx;
            end
            mrun[i] = en[i];
        end
        if (cfg_valid && rdy) begin
            sd[cfg_ch] = cfg_div;
            sh[cfg_ch] = cfg_high;
`ifdef CLKDIV_PHASE_EN
            sp[cfg_ch] = cfg_phase;
`else
            sp[cfg_ch] = 0;
`endif
            mpend[cfg_ch] = 1;
        end
    endtask

    task automatic step();
        @(posedge I_CLK);
        model_edge();
        #1;
    endtask

    task automatic do_write(int ch, int d, int h);
        int n;
        bit done;
        n    = 0;
        done = 0;
        cfg_ch    = 2'(ch);
        cfg_div   = W'(d);
        cfg_high  = W'(h);
        cfg_valid = 1'b1;
        #1;
        while (!done && n < 100) begin
            done = cfg_ready;
            step();
            n++;
        end
        cfg_valid = 1'b0;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL write_timeout: ch=%0d cfg_ready stayed %b, required 1", ch, cfg_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = '0;
        #7;
        n_checks++;
        if (O_CLK !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_oclk: got %b, expected 0000", O_CLK);
        end
        n_checks++;
        if (tick !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_tick: got %b, expected 0000", tick);
        end
        n_checks++;
        if (cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b, expected 1", cfg_ready);
        end
        @(negedge I_CLK);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_default();
        bit eo;
        bit et;
        cfg_ch = 2'd0;
        en[0]  = 1'b1;
        for (int k = 0; k < 60; k++) begin
            step();
            eo = (k % 20) >= 10;
            et = (k % 20) == 10;
            n_checks++;
            if (O_CLK[0] !== eo || tick[0] !== et) begin
                n_fail++;
                $display("FAIL default_wave k=%0d: O_CLK=%b tick=%b, expected %b %b", k, O_CLK[0], tick[0], eo, et);
            end
            n_checks++;
            if (O_CLK !== mo || tick !== mt || cfg_ready !== !mpend[cfg_ch]) begin
                n_fail++;
                $display("FAIL default_model k=%0d: O_CLK=%b tick=%b rdy=%b, expected %b %b %b", k, O_CLK, tick, cfg_ready, mo, mt, !mpend[cfg_ch]);
            end
        end
    endtask

    task automatic test_reconfig();
        bit eo;
        bit er;
        do_write(1, 8, 4);
        step();
        cfg_ch = 2'd1;
        en[1]  = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (k == 4) cfg_valid = 1'b0;
            eo = (k < 8) ? ((k % 8) >= 4) : (((k - 8) % 5) >= 3);
            er = !(k >= 4 && k < 8);
            n_checks++;
            if (O_CLK[1] !== eo || cfg_ready !== er) begin
                n_fail++;
                $display("FAIL reconfig k=%0d: O_CLK1=%b rdy=%b, expected %b %b", k, O_CLK[1], cfg_ready, eo, er);
            end
            n_checks++;
            if (O_CLK !== mo || tick !== mt || cfg_ready !== !mpend[cfg_ch]) begin
                n_fail++;
                $display("FAIL reconfig_model k=%0d: O_CLK=%b tick=%b rdy=%b, expected %b %b %b", k, O_CLK, tick, cfg_ready, mo, mt, !mpend[cfg_ch]);
            end
            if (k == 3) begin
                cfg_div   = W'(5);
                cfg_high  = W'(2);
                cfg_valid = 1'b1;
            end
        end
    endtask

    task automatic test_edge_cases();
        int ticks;
        do_write(3, 0, 1);
        step();
        en[3] = 1'b1;
        ticks = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            ticks += int'(tick[3]);
            n_checks++;
            if (O_CLK[3] !== 1'(k % 2) || O_CLK !== mo || tick !== mt) begin
                n_fail++;
                $display("FAIL div0_wave k=%0d: O_CLK=%b tick=%b, expected %b %b", k, O_CLK, tick, mo, mt);
            end
        end
        n_checks++;
        if (ticks !== 5) begin
            n_fail++;
            $display("FAIL div0_ticks: got %0d, expected 5", ticks);
        end
        do_write(3, 0, 0);
        for (int k = 0; k < 4; k++) step();
        for (int k = 0; k < 10; k++) begin
            step();
            n_checks++;
            if (O_CLK[3] !== 1'b0 || tick[3] !== 1'b0 || O_CLK !== mo || tick !== mt) begin
                n_fail++;
                $display("FAIL high0 k=%0d: O_CLK=%b tick=%b, expected %b %b", k, O_CLK, tick, mo, mt);
            end
        end
        do_write(3, 4, 9);
        ticks = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            ticks += int'(tick[3]);
            n_checks++;
            if (O_CLK !== mo || tick !== mt) begin
                n_fail++;
                $display("FAIL high_full k=%0d: O_CLK=%b tick=%b, expected %b %b", k, O_CLK, tick, mo, mt);
            end
        end
        n_checks++;
        if (ticks !== 1 || O_CLK[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL high_full_sum: ticks=%0d O_CLK3=%b, expected 1 1", ticks, O_CLK[3]);
        end
    endtask

    task automatic test_sync();
        do_write(0, 6, 3);
        do_write(2, 12, 6);
        for (int k = 0; k < 22; k++) step();
        en[2] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            n_checks++;
            if (O_CLK !== mo || tick !== mt) begin
                n_fail++;
                $display("FAIL presync k=%0d: O_CLK=%b tick=%b, expected %b %b", k, O_CLK, tick, mo, mt);
            end
        end
        sync = 1'b1;
        step();
        sync = 1'b0;
        n_checks++;
        if (tick !== 4'b0000 || O_CLK[0] !== 1'b0 || O_CLK[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL sync_edge: O_CLK=%b tick=%b, expected x0x0 0000", O_CLK, tick);
        end
        for (int s = 1; s < 13; s++) begin
            step();
            n_checks++;
            if (O_CLK[0] !== ((s % 6) >= 3) || O_CLK[2] !== ((s % 12) >= 6)) begin
                n_fail++;
                $display("FAIL sync_align s=%0d: O_CLK=%b, expected bit0=%b bit2=%b", s, O_CLK, (s % 6) >= 3, (s % 12) >= 6);
            end
            n_checks++;
            if (O_CLK !== mo || tick !== mt) begin
                n_fail++;
                $display("FAIL sync_model s=%0d: O_CLK=%b tick=%b, expected %b %b", s, O_CLK, tick, mo, mt);
            end
        end
    endtask

`ifdef CLKDIV_PHASE_EN
    task automatic test_phase();
        bit eo;
        en[1] = 1'b0;
        step();
        cfg_phase = W'(7);
        do_write(1, 10, 5);
        step();
        en[1] = 1'b1;
        for (int k = 0; k < 13; k++) begin
            step();
            eo = ((7 + k) % 10) >= 5;
            n_checks++;
            if (O_CLK[1] !== eo || O_CLK !== mo || tick !== mt) begin
                n_fail++;
                $display("FAIL phase7 k=%0d: O_CLK=%b tick=%b, expected bit1=%b model %b %b", k, O_CLK, tick, eo, mo, mt);
            end
        end
        en[1] = 1'b0;
        step();
        cfg_phase = W'(12);
        do_write(1, 10, 5);
        step();
        en[1] = 1'b1;
        for (int k = 0; k < 13; k++) begin
            step();
            eo = (k % 10) >= 5;
            n_checks++;
            if (O_CLK[1] !== eo || O_CLK !== mo || tick !== mt) begin
                n_fail++;
                $display("FAIL phase12 k=%0d: O_CLK=%b tick=%b, expected bit1=%b model %b %b", k, O_CLK, tick, eo, mo, mt);
            end
        end
    endtask
`endif

    task automatic test_async_reset();
        int n;
        en = 4'b1111;
        n  = 0;
        while (tick[0] !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        n_checks++;
        if (tick[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_wait: tick0=%b never rose, required 1", tick[0]);
        end
        cfg_ch    = 2'd2;
        cfg_div   = W'(3);
        cfg_high  = W'(1);
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        n_checks++;
        if (cfg_ready !== 1'b0 || O_CLK[0] !== 1'b1 || O_CLK !== mo) begin
            n_fail++;
            $display("FAIL arst_pre: rdy=%b O_CLK=%b, expected 0 and %b", cfg_ready, O_CLK, mo);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (O_CLK !== 4'b0000 || tick !== 4'b0000 || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_async: O_CLK=%b tick=%b rdy=%b, expected 0000 0000 1", O_CLK, tick, cfg_ready);
        end
        @(negedge I_CLK);
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 45; k++) begin
            step();
            n_checks++;
            if (O_CLK[0] !== ((k % 20) >= 10) || O_CLK[2] !== ((k % 20) >= 10)) begin
                n_fail++;
                $display("FAIL arst_defaults k=%0d: O_CLK=%b, expected bits0,2=%b", k, O_CLK, (k % 20) >= 10);
            end
            n_checks++;
            if (O_CLK !== mo || tick !== mt || cfg_ready !== !mpend[cfg_ch]) begin
                n_fail++;
                $display("FAIL arst_model k=%0d: O_CLK=%b tick=%b rdy=%b, expected %b %b %b", k, O_CLK, tick, cfg_ready, mo, mt, !mpend[cfg_ch]);
            end
        end
    endtask

    task automatic test_random();
        int idx;
        for (int k = 0; k < 1500; k++) begin
            step();
            n_checks++;
            if (O_CLK !== mo || tick !== mt || cfg_ready !== !mpend[cfg_ch]) begin
                n_fail++;
                $display("FAIL random k=%0d: O_CLK=%b tick=%b rdy=%b, expected %b %b %b", k, O_CLK, tick, cfg_ready, mo, mt, !mpend[cfg_ch]);
            end
            if ($urandom_range(0, 19) == 0) begin
                idx     = int'($urandom_range(0, CH - 1));
                en[idx] = ~en[idx];
            end
            sync      = ($urandom_range(0, 39) == 0);
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_ch    = 2'($urandom_range(0, 3));
            cfg_div   = W'($urandom_range(0, 9));
            cfg_high  = W'($urandom_range(0, 11));
`ifdef CLKDIV_PHASE_EN
            cfg_phase = W'($urandom_range(0, 12));
`endif
        end
        sync      = 1'b0;
        cfg_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_default();
        test_reconfig();
        test_edge_cases();
        test_sync();
`ifdef CLKDIV_PHASE_EN
        test_phase();
`endif
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
